// File: rtl/rs_bank.sv
// rs_bank: parametrised reservation-station bank.
// NUM_ENTRIES slots hold the payload, the destination tag and two source operands.
// NUM_CDB broadcast ports wake waiting sources. Select is oldest-first through an age matrix.
// Optional feature macro: RS_WAKEUP_BYPASS_EN. When defined, a source matched on the
// CDB this cycle counts as ready for select, and its operand is forwarded straight to issue.
module rs_bank #(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_CDB     = 2,
    parameter int TAG_W       = 5,
    parameter int DATA_W      = 32,
    parameter int PAYLOAD_W   = 64
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              dispatch_valid,
    output logic                              dispatch_ready,
    input  logic [PAYLOAD_W-1:0]              disp_payload,
    input  logic [TAG_W-1:0]                  disp_dest_tag,
    input  logic [TAG_W-1:0]                  disp_rs1_tag,
    input  logic [TAG_W-1:0]                  disp_rs2_tag,
    input  logic                              disp_rs1_ready,
    input  logic                              disp_rs2_ready,
    input  logic [DATA_W-1:0]                 disp_rs1_value,
    input  logic [DATA_W-1:0]                 disp_rs2_value,
    input  logic [NUM_CDB-1:0]                cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]          cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]         cdb_value,
    output logic                              issue_valid,
    input  logic                              issue_ack,
    output logic [PAYLOAD_W-1:0]              issue_payload,
    output logic [TAG_W-1:0]                  issue_dest_tag,
    output logic [DATA_W-1:0]                 issue_rs1_value,
    output logic [DATA_W-1:0]                 issue_rs2_value,
    input  logic                              squash,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]  free_count
);

    localparam int FC_W  = $clog2(NUM_ENTRIES + 1);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    // Returns {hit, value} for a tag. The lowest-index valid port that matches wins.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, vals[p*DATA_W +: DATA_W]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Slot state
    logic [NUM_ENTRIES-1:0] busy_q, busy_d;
    logic [NUM_ENTRIES-1:0] rs1_rdy_q, rs1_rdy_d;
    logic [NUM_ENTRIES-1:0] rs2_rdy_q, rs2_rdy_d;
    logic [TAG_W-1:0]       rs1_tag_q [NUM_ENTRIES];
    logic [TAG_W-1:0]       rs1_tag_d [NUM_ENTRIES];
    logic [TAG_W-1:0]       rs2_tag_q [NUM_ENTRIES];
    logic [TAG_W-1:0]       rs2_tag_d [NUM_ENTRIES];
    logic [DATA_W-1:0]      rs1_val_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      rs1_val_d [NUM_ENTRIES];
    logic [DATA_W-1:0]      rs2_val_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      rs2_val_d [NUM_ENTRIES];
    logic [TAG_W-1:0]       dest_q    [NUM_ENTRIES];
    logic [TAG_W-1:0]       dest_d    [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   payload_q [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   payload_d [NUM_ENTRIES];
    // age_q[j][i] = 1 means slot j is older than slot i
    logic [NUM_ENTRIES-1:0] age_q     [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] age_d     [NUM_ENTRIES];
    logic [FC_W-1:0]        free_count_q, free_count_d;
    logic                   dispatch_ready_q, dispatch_ready_d;

    // Wakeup matches and selection helpers
    logic [NUM_ENTRIES-1:0] rs1_hit_s, rs2_hit_s;
    logic [DATA_W-1:0]      rs1_cdb_s [NUM_ENTRIES];
    logic [DATA_W-1:0]      rs2_cdb_s [NUM_ENTRIES];
    logic                   disp_rs1_hit_s, disp_rs2_hit_s;
    logic [DATA_W-1:0]      disp_rs1_cdb_s, disp_rs2_cdb_s;
    logic [NUM_ENTRIES-1:0] slot_rdy_s;
    logic [DATA_W-1:0]      op1_s [NUM_ENTRIES];
    logic [DATA_W-1:0]      op2_s [NUM_ENTRIES];
    logic [IDX_W-1:0]       sel_idx_s;
    logic                   sel_found_s;
    logic [IDX_W-1:0]       disp_idx_s;
    logic                   disp_found_s;
    logic                   dispatch_fire_s;
    logic                   issue_fire_s;

    assign dispatch_ready = dispatch_ready_q;
    assign free_count     = free_count_q;

    // Compare every stored source tag and every dispatching source tag against the CDB
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            {rs1_hit_s[i], rs1_cdb_s[i]} = cdb_lookup(rs1_tag_q[i], cdb_valid, cdb_tag, cdb_value);
            {rs2_hit_s[i], rs2_cdb_s[i]} = cdb_lookup(rs2_tag_q[i], cdb_valid, cdb_tag, cdb_value);
        end
        {disp_rs1_hit_s, disp_rs1_cdb_s} = cdb_lookup(disp_rs1_tag, cdb_valid, cdb_tag, cdb_value);
        {disp_rs2_hit_s, disp_rs2_cdb_s} = cdb_lookup(disp_rs2_tag, cdb_valid, cdb_tag, cdb_value);
    end

    // Readiness and operand values used by select (registered, or with same-cycle forwarding)
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            slot_rdy_s[i] = busy_q[i] & (rs1_rdy_q[i] | rs1_hit_s[i]) & (rs2_rdy_q[i] | rs2_hit_s[i]);
            op1_s[i]      = rs1_rdy_q[i] ? rs1_val_q[i] : rs1_cdb_s[i];
            op2_s[i]      = rs2_rdy_q[i] ? rs2_val_q[i] : rs2_cdb_s[i];
`else
            slot_rdy_s[i] = busy_q[i] & rs1_rdy_q[i] & rs2_rdy_q[i];
            op1_s[i]      = rs1_val_q[i];
            op2_s[i]      = rs2_val_q[i];
`endif
        end
    end

    // Oldest-first select: a ready slot wins when no other ready slot is older than it
    always_comb begin
        logic older_v;
        sel_idx_s   = '0;
        sel_found_s = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            older_v = 1'b0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (slot_rdy_s[j] && age_q[j][i]) begin
                    older_v = 1'b1;
                end else begin
                    older_v = older_v;
                end
            end
            if (slot_rdy_s[i] && !older_v && !sel_found_s) begin
                sel_idx_s   = IDX_W'(i);
                sel_found_s = 1'b1;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Lowest-index free slot receives the next dispatch
    always_comb begin
        disp_idx_s   = '0;
        disp_found_s = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!busy_q[i] && !disp_found_s) begin
                disp_idx_s   = IDX_W'(i);
                disp_found_s = 1'b1;
            end else begin
                disp_found_s = disp_found_s;
            end
        end
        dispatch_fire_s = dispatch_valid & dispatch_ready_q & disp_found_s;
        issue_fire_s    = issue_ack & sel_found_s;
    end

    // Present the selected slot. All issue data outputs are zero when nothing is ready.
    always_comb begin
        issue_valid = sel_found_s;
        if (sel_found_s) begin
            issue_payload   = payload_q[sel_idx_s];
            issue_dest_tag  = dest_q[sel_idx_s];
            issue_rs1_value = op1_s[sel_idx_s];
            issue_rs2_value = op2_s[sel_idx_s];
        end else begin
            issue_payload   = '0;
            issue_dest_tag  = '0;
            issue_rs1_value = '0;
            issue_rs2_value = '0;
        end
    end

    // Next slot state: wakeup, issue free, dispatch write, then squash overriding everything
    always_comb begin
        logic [FC_W-1:0] fc_v;
        busy_d    = busy_q;
        rs1_rdy_d = rs1_rdy_q;
        rs2_rdy_d = rs2_rdy_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            rs1_tag_d[i] = rs1_tag_q[i];
            rs2_tag_d[i] = rs2_tag_q[i];
            rs1_val_d[i] = rs1_val_q[i];
            rs2_val_d[i] = rs2_val_q[i];
            dest_d[i]    = dest_q[i];
            payload_d[i] = payload_q[i];
            age_d[i]     = age_q[i];
        end

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (busy_q[i] && !rs1_rdy_q[i] && rs1_hit_s[i]) begin
                rs1_rdy_d[i] = 1'b1;
                rs1_val_d[i] = rs1_cdb_s[i];
            end else begin
                rs1_rdy_d[i] = rs1_rdy_d[i];
            end
            if (busy_q[i] && !rs2_rdy_q[i] && rs2_hit_s[i]) begin
                rs2_rdy_d[i] = 1'b1;
                rs2_val_d[i] = rs2_cdb_s[i];
            end else begin
                rs2_rdy_d[i] = rs2_rdy_d[i];
            end
        end

        if (issue_fire_s) begin
            busy_d[sel_idx_s] = 1'b0;
        end else begin
            busy_d = busy_d;
        end

        if (dispatch_fire_s) begin
            busy_d[disp_idx_s]    = 1'b1;
            rs1_tag_d[disp_idx_s] = disp_rs1_tag;
            rs2_tag_d[disp_idx_s] = disp_rs2_tag;
            rs1_rdy_d[disp_idx_s] = disp_rs1_ready | disp_rs1_hit_s;
            rs2_rdy_d[disp_idx_s] = disp_rs2_ready | disp_rs2_hit_s;
            rs1_val_d[disp_idx_s] = disp_rs1_ready ? disp_rs1_value : disp_rs1_cdb_s;
            rs2_val_d[disp_idx_s] = disp_rs2_ready ? disp_rs2_value : disp_rs2_cdb_s;
            dest_d[disp_idx_s]    = disp_dest_tag;
            payload_d[disp_idx_s] = disp_payload;
            // The new slot is younger than every slot already busy
            age_d[disp_idx_s]     = '0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                age_d[j][disp_idx_s] = busy_q[j];
            end
        end else begin
            busy_d = busy_d;
        end

        if (squash) begin
            busy_d = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age_d[i] = '0;
            end
        end else begin
            busy_d = busy_d;
        end

        fc_v = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            fc_v = fc_v + FC_W'(~busy_d[i]);
        end
        free_count_d     = fc_v;
        dispatch_ready_d = (fc_v != {FC_W{1'b0}});
    end

    // Slot, age and occupancy registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q           <= '0;
            rs1_rdy_q        <= '0;
            rs2_rdy_q        <= '0;
            free_count_q     <= FC_W'(NUM_ENTRIES);
            dispatch_ready_q <= 1'b1;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                rs1_tag_q[i] <= '0;
                rs2_tag_q[i] <= '0;
                rs1_val_q[i] <= '0;
                rs2_val_q[i] <= '0;
                dest_q[i]    <= '0;
                payload_q[i] <= '0;
                age_q[i]     <= '0;
            end
        end else begin
            busy_q           <= busy_d;
            rs1_rdy_q        <= rs1_rdy_d;
            rs2_rdy_q        <= rs2_rdy_d;
            free_count_q     <= free_count_d;
            dispatch_ready_q <= dispatch_ready_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                rs1_tag_q[i] <= rs1_tag_d[i];
                rs2_tag_q[i] <= rs2_tag_d[i];
                rs1_val_q[i] <= rs1_val_d[i];
                rs2_val_q[i] <= rs2_val_d[i];
                dest_q[i]    <= dest_d[i];
                payload_q[i] <= payload_d[i];
                age_q[i]     <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_bank.sv
// Testbench for rs_bank: directed scenarios plus randomized traffic checked
// against a queue-based model that keeps entries in dispatch order.
module tb_rs_bank;
    localparam int N  = 8;
    localparam int NC = 2;
    localparam int TW = 5;
    localparam int DW = 32;
    localparam int PW = 64;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           dispatch_valid, dispatch_ready;
    logic [PW-1:0]  disp_payload;
    logic [TW-1:0]  disp_dest_tag, disp_rs1_tag, disp_rs2_tag;
    logic           disp_rs1_ready, disp_rs2_ready;
    logic [DW-1:0]  disp_rs1_value, disp_rs2_value;
    logic [NC-1:0]  cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*DW-1:0] cdb_value;
    logic           issue_valid, issue_ack;
    logic [PW-1:0]  issue_payload;
    logic [TW-1:0]  issue_dest_tag;
    logic [DW-1:0]  issue_rs1_value, issue_rs2_value;
    logic           squash;
    logic [3:0]     free_count;

    rs_bank #(.NUM_ENTRIES(N), .NUM_CDB(NC), .TAG_W(TW), .DATA_W(DW), .PAYLOAD_W(PW)) dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .disp_payload(disp_payload), .disp_dest_tag(disp_dest_tag),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_ready(disp_rs1_ready), .disp_rs2_ready(disp_rs2_ready),
        .disp_rs1_value(disp_rs1_value), .disp_rs2_value(disp_rs2_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ack(issue_ack),
        .issue_payload(issue_payload), .issue_dest_tag(issue_dest_tag),
        .issue_rs1_value(issue_rs1_value), .issue_rs2_value(issue_rs2_value),
        .squash(squash), .free_count(free_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [PW-1:0] payload;
        logic [TW-1:0] dest;
        logic          r1, r2;
        logic [TW-1:0] t1, t2;
        logic [DW-1:0] v1, v2;
    } ent_t;

    ent_t mq[$];
    int   checks = 0;
    int   errors = 0;

    logic          exp_valid;
    int            exp_idx;
    logic [PW-1:0] exp_payload;
    logic [TW-1:0] exp_dest;
    logic [DW-1:0] exp_v1, exp_v2;

    function automatic void cdb_find(input logic [TW-1:0] tag, output logic hit, output logic [DW-1:0] val);
        hit = 1'b0;
        val = '0;
        for (int p = 0; p < NC; p++) begin
            if (!hit && cdb_valid[p] && cdb_tag[p*TW +: TW] == tag) begin
                hit = 1'b1;
                val = cdb_value[p*DW +: DW];
            end
        end
    endfunction

    // Expected issue outputs: the first (oldest) model entry whose sources are ready
    function automatic void model_outputs();
        logic r1, r2, h;
        logic [DW-1:0] v1, v2, cv;
        exp_valid = 1'b0; exp_idx = -1; exp_payload = '0; exp_dest = '0; exp_v1 = '0; exp_v2 = '0;
        for (int k = 0; k < mq.size(); k++) begin
            r1 = mq[k].r1; v1 = mq[k].v1;
            r2 = mq[k].r2; v2 = mq[k].v2;
`ifdef RS_WAKEUP_BYPASS_EN
            if (!r1) begin cdb_find(mq[k].t1, h, cv); if (h) begin r1 = 1'b1; v1 = cv; end end
            if (!r2) begin cdb_find(mq[k].t2, h, cv); if (h) begin r2 = 1'b1; v2 = cv; end end
`endif
            if (exp_idx < 0 && r1 && r2) begin
                exp_idx = k; exp_valid = 1'b1;
                exp_payload = mq[k].payload; exp_dest = mq[k].dest; exp_v1 = v1; exp_v2 = v2;
            end
        end
    endfunction

    // Advance one clock edge, applying the same edge to the model
    task automatic tick();
        ent_t e;
        int   n_before;
        logic h;
        logic [DW-1:0] cv;
        model_outputs();
        n_before = mq.size();
        if (squash) begin
            mq.delete();
        end else begin
            for (int k = 0; k < mq.size(); k++) begin
                e = mq[k];
                if (!e.r1) begin cdb_find(e.t1, h, cv); if (h) begin e.r1 = 1'b1; e.v1 = cv; end end
                if (!e.r2) begin cdb_find(e.t2, h, cv); if (h) begin e.r2 = 1'b1; e.v2 = cv; end end
                mq[k] = e;
            end
            if (issue_ack && exp_valid) mq.delete(exp_idx);
            if (dispatch_valid && n_before < N) begin
                e.payload = disp_payload; e.dest = disp_dest_tag;
                e.t1 = disp_rs1_tag; e.t2 = disp_rs2_tag;
                e.r1 = disp_rs1_ready; e.v1 = disp_rs1_value;
                e.r2 = disp_rs2_ready; e.v2 = disp_rs2_value;
                if (!e.r1) begin cdb_find(e.t1, h, cv); if (h) begin e.r1 = 1'b1; e.v1 = cv; end end
                if (!e.r2) begin cdb_find(e.t2, h, cv); if (h) begin e.r2 = 1'b1; e.v2 = cv; end end
                mq.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0; disp_payload = '0; disp_dest_tag = '0;
        disp_rs1_tag = '0; disp_rs2_tag = '0; disp_rs1_ready = 1'b0; disp_rs2_ready = 1'b0;
        disp_rs1_value = '0; disp_rs2_value = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        issue_ack = 1'b0; squash = 1'b0;
    endtask

    task automatic set_disp(input logic [TW-1:0] dest, input logic [TW-1:0] t1, input logic r1, input logic [DW-1:0] v1,
                            input logic [TW-1:0] t2, input logic r2, input logic [DW-1:0] v2);
        dispatch_valid = 1'b1; disp_payload = {$urandom, $urandom}; disp_dest_tag = dest;
        disp_rs1_tag = t1; disp_rs1_ready = r1; disp_rs1_value = v1;
        disp_rs2_tag = t2; disp_rs2_ready = r2; disp_rs2_value = v2;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %0d want 0", issue_valid); end
        checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_dispatch_ready got %0d want 1", dispatch_ready); end
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL reset_free_count got %0d want 8", free_count); end
        checks++; if (issue_payload !== 64'd0 || issue_rs1_value !== 32'd0 || issue_rs2_value !== 32'd0 || issue_dest_tag !== 5'd0) begin
            errors++; $display("FAIL reset_issue_data got %h/%h/%h/%h want zeros", issue_payload, issue_rs1_value, issue_rs2_value, issue_dest_tag);
        end
        mq.delete();
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        logic [PW-1:0] pl;
        set_disp(5'd3, 5'd1, 1'b1, 32'd5, 5'd1, 1'b1, 32'd7);
        pl = disp_payload;
        @(negedge clock);
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_valid got %0d want 0", issue_valid); end
        tick(); idle();
        @(negedge clock);
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d want 1", issue_valid); end
        checks++; if (issue_rs1_value !== 32'd5 || issue_rs2_value !== 32'd7) begin errors++; $display("FAIL basic_values got %0d/%0d want 5/7", issue_rs1_value, issue_rs2_value); end
        checks++; if (issue_dest_tag !== 5'd3 || issue_payload !== pl) begin errors++; $display("FAIL basic_dest_payload got %0d/%h want 3/%h", issue_dest_tag, issue_payload, pl); end
        issue_ack = 1'b1;
        tick(); idle();
        @(negedge clock);
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL basic_free_after_ack got %0d want 8", free_count); end
        tick();
    endtask

    task automatic test_wakeup();
        set_disp(5'd9, 5'd2, 1'b0, 32'd0, 5'd0, 1'b1, 32'd3);
        tick(); idle();
        cdb_valid = 2'b10; cdb_tag = {5'd2, 5'd0}; cdb_value = {32'd10, 32'd0};
        @(negedge clock);
`ifdef RS_WAKEUP_BYPASS_EN
        checks++; if (issue_valid !== 1'b1 || issue_rs1_value !== 32'd10) begin errors++; $display("FAIL wakeup_bypass got %0d/%0d want 1/10", issue_valid, issue_rs1_value); end
`else
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wakeup_broadcast_cycle got %0d want 0", issue_valid); end
`endif
        tick(); idle();
        @(negedge clock);
        checks++; if (issue_valid !== 1'b1 || issue_rs1_value !== 32'd10 || issue_rs2_value !== 32'd3) begin
            errors++; $display("FAIL wakeup_next got %0d/%0d/%0d want 1/10/3", issue_valid, issue_rs1_value, issue_rs2_value);
        end
        issue_ack = 1'b1;
        tick(); idle();
    endtask

    task automatic test_two_wakeups();
        set_disp(5'd11, 5'd3, 1'b0, 32'd0, 5'd4, 1'b0, 32'd0);
        tick(); idle();
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd4}; cdb_value = {32'd0, 32'd10};
        tick(); idle();
        @(negedge clock);
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL two_wake_first got %0d want 0", issue_valid); end
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd3}; cdb_value = {32'd0, 32'd10};
        tick(); idle();
        @(negedge clock);
        checks++; if (issue_valid !== 1'b1 || issue_rs1_value !== 32'd10 || issue_rs2_value !== 32'd10 || issue_dest_tag !== 5'd11) begin
            errors++; $display("FAIL two_wake_second got %0d/%0d/%0d/%0d want 1/10/10/11", issue_valid, issue_rs1_value, issue_rs2_value, issue_dest_tag);
        end
        issue_ack = 1'b1;
        tick(); idle();
    endtask

    task automatic test_capture();
        set_disp(5'd12, 5'd6, 1'b0, 32'd0, 5'd0, 1'b1, 32'd1);
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd6}; cdb_value = {32'd0, 32'd99};
        tick(); idle();
        @(negedge clock);
        checks++; if (issue_valid !== 1'b1 || issue_rs1_value !== 32'd99) begin errors++; $display("FAIL capture got %0d/%0d want 1/99", issue_valid, issue_rs1_value); end
        issue_ack = 1'b1;
        tick(); idle();
    endtask

    task automatic test_full();
        logic [TW-1:0] order [9];
        for (int k = 0; k < N; k++) begin
            set_disp(TW'(k + 1), 5'd1, 1'b1, DW'(k), 5'd1, 1'b1, DW'(k + 100));
            tick();
        end
        idle();
        @(negedge clock);
        checks++; if (dispatch_ready !== 1'b0 || free_count !== 4'd0) begin errors++; $display("FAIL full_state got %0d/%0d want 0/0", dispatch_ready, free_count); end
        checks++; if (issue_dest_tag !== 5'd1) begin errors++; $display("FAIL full_oldest got %0d want 1", issue_dest_tag); end
        issue_ack = 1'b1;
        set_disp(5'd20, 5'd1, 1'b1, 32'd20, 5'd1, 1'b1, 32'd21);
        tick();
        issue_ack = 1'b0;
        @(negedge clock);
        checks++; if (free_count !== 4'd1 || dispatch_ready !== 1'b1) begin errors++; $display("FAIL full_ack_free got %0d/%0d want 1/1", free_count, dispatch_ready); end
        tick(); idle();
        for (int k = 0; k < 7; k++) order[k] = TW'(k + 2);
        order[7] = 5'd20;
        for (int k = 0; k < N; k++) begin
            @(negedge clock);
            checks++; if (issue_valid !== 1'b1 || issue_dest_tag !== order[k]) begin
                errors++; $display("FAIL full_order_%0d got %0d/%0d want 1/%0d", k, issue_valid, issue_dest_tag, order[k]);
            end
            issue_ack = 1'b1;
            tick();
        end
        idle();
        @(negedge clock);
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL full_drained got %0d want 8", free_count); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            dispatch_valid = ($urandom_range(0, 9) < 6);
            disp_payload   = {$urandom, $urandom};
            disp_dest_tag  = TW'($urandom_range(1, 31));
            disp_rs1_tag   = TW'($urandom_range(1, 7));
            disp_rs2_tag   = TW'($urandom_range(1, 7));
            disp_rs1_ready = $urandom_range(0, 1);
            disp_rs2_ready = $urandom_range(0, 1);
            disp_rs1_value = $urandom;
            disp_rs2_value = $urandom;
            for (int p = 0; p < NC; p++) begin
                cdb_valid[p]          = $urandom_range(0, 1);
                cdb_tag[p*TW +: TW]   = TW'($urandom_range(1, 7));
                cdb_value[p*DW +: DW] = $urandom;
            end
            issue_ack = $urandom_range(0, 1);
            squash    = ($urandom_range(0, 49) == 0);
            @(negedge clock);
            model_outputs();
            checks++; if (issue_valid !== exp_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %0d want %0d", c, issue_valid, exp_valid); end
            checks++; if (issue_payload !== exp_payload || issue_dest_tag !== exp_dest) begin
                errors++; $display("FAIL rand_payload_dest cyc %0d got %h/%0d want %h/%0d", c, issue_payload, issue_dest_tag, exp_payload, exp_dest);
            end
            checks++; if (issue_rs1_value !== exp_v1 || issue_rs2_value !== exp_v2) begin
                errors++; $display("FAIL rand_operands cyc %0d got %h/%h want %h/%h", c, issue_rs1_value, issue_rs2_value, exp_v1, exp_v2);
            end
            checks++; if (free_count !== 4'(N - mq.size()) || dispatch_ready !== (mq.size() < N)) begin
                errors++; $display("FAIL rand_occupancy cyc %0d got %0d/%0d want %0d/%0d", c, free_count, dispatch_ready, N - mq.size(), mq.size() < N);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_squash();
        squash = 1'b1;
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            set_disp(TW'(k + 1), 5'd1, 1'b1, 32'd1, 5'd1, 1'b1, 32'd2);
            tick();
        end
        set_disp(5'd9, 5'd1, 1'b1, 32'd1, 5'd1, 1'b1, 32'd2);
        issue_ack = 1'b1; squash = 1'b1;
        tick(); idle();
        @(negedge clock);
        checks++; if (free_count !== 4'd8 || issue_valid !== 1'b0 || dispatch_ready !== 1'b1) begin
            errors++; $display("FAIL squash got %0d/%0d/%0d want 8/0/1", free_count, issue_valid, dispatch_ready);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            set_disp(TW'(k + 4), 5'd1, 1'b1, 32'd33, 5'd1, 1'b1, 32'd44);
            tick();
        end
        idle();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0 || free_count !== 4'd8 || dispatch_ready !== 1'b1 || issue_rs1_value !== 32'd0) begin
            errors++; $display("FAIL async_reset got %0d/%0d/%0d/%0d want 0/8/1/0", issue_valid, free_count, dispatch_ready, issue_rs1_value);
        end
        mq.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        test_reset();
        test_basic();
        test_wakeup();
        test_two_wakeups();
        test_capture();
        test_full();
        test_random();
        test_squash();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Multi-entry reservation station. It replaces per-entry instantiation with one parametrised bank of NUM_ENTRIES slots that are woken by NUM_CDB parallel CDB broadcast ports.
- Sits between dispatch (map table, ROB tag allocation) and the functional-unit issue port.
- Holds decoded payload, destination ROB tag and two source operands per slot; selects the oldest fully-ready slot for issue each cycle.

Parameters:
NUM_ENTRIES, 8, number of slots (power of two, >=2)
NUM_CDB, 2, number of CDB broadcast ports
TAG_W, 5, ROB tag width; tag 0 is never a valid producer tag
DATA_W, 32, operand width
PAYLOAD_W, 64, opaque decoded-instruction bits carried to issue

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
dispatch_valid  in  1  dispatch request this cycle
dispatch_ready  out  1  at least one free slot (registered state only)
disp_payload  in  PAYLOAD_W  decoded instruction bits
disp_dest_tag  in  TAG_W  ROB entry of this instruction
disp_rs1_tag / disp_rs2_tag  in  TAG_W  producer tags from map table
disp_rs1_ready / disp_rs2_ready  in  1  1 = value supplied at dispatch (regfile or ROB)
disp_rs1_value / disp_rs2_value  in  DATA_W  operand values, valid when the ready bit is set
cdb_valid  in  NUM_CDB  per-port broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  packed broadcast tags, port 0 in LSBs
cdb_value  in  NUM_CDB*DATA_W  packed broadcast values
issue_valid  out  1  a ready slot is presented
issue_ack  in  1  consumer takes the presented slot this cycle
issue_payload  out  PAYLOAD_W  selected slot payload
issue_dest_tag  out  TAG_W  selected slot destination tag
issue_rs1_value / issue_rs2_value  out  DATA_W  selected slot operands
squash  in  1  flush all slots (branch mispredict)
free_count  out  $clog2(NUM_ENTRIES+1)  number of free slots

Behaviour:
- Reset (reset=0, asynchronous):
  - All slots go not-busy and the age matrix clears.
  - dispatch_ready=1, issue_valid=0, free_count=NUM_ENTRIES.
  - issue_* data outputs are 0.
- Slot state: busy, rs1_rdy, rs2_rdy, rs1_tag, rs2_tag, rs1_val, rs2_val, dest_tag, payload. A slot is ready when busy & rs1_rdy & rs2_rdy.
- Dispatch:
  - On a clock edge where dispatch_valid & dispatch_ready, write the lowest-index free slot.
  - dispatch_valid while !dispatch_ready is ignored. The sender must hold the request.
  - A slot freed by issue_ack in the same cycle is not reusable until the next cycle.
- Dispatch-cycle capture: if a source is not ready at dispatch and a valid CDB port broadcasts its tag in the same cycle, the slot captures that value and sets the ready bit at the edge.
- Wakeup:
  - Each cycle, every busy slot compares each non-ready source tag against all valid CDB ports.
  - On a match, the value is latched and the ready bit set at the edge.
  - If several ports match the same tag, the lowest port index wins.
- Issue latency: an entry is issue-eligible in the cycle after its last operand becomes ready (registered wakeup). A slot dispatched fully ready can issue the cycle after dispatch.
- Select:
  - Combinational oldest-first among ready slots, using an NxN age matrix updated at dispatch. A new slot is younger than all busy slots.
  - issue_valid = any slot ready; the issue_* outputs show the selected slot.
  - The presented slot may change between cycles while unacked.
  - issue_ack with issue_valid=1 frees the presented slot at the edge. issue_ack with issue_valid=0 is ignored.
- Squash: all slots go not-busy at the edge. Squash overrides dispatch and issue_ack in the same cycle.
- free_count and dispatch_ready reflect registered state: dispatch_ready = (free_count != 0).
- Full: free_count=0, dispatch_ready=0. An issue_ack that cycle makes free_count=1 next cycle.
- Empty: issue_valid=0 and the issue_* data outputs hold 0.

Optional Feature:
RS_WAKEUP_BYPASS_EN
- Defined: select treats a busy slot as ready if each source is ready or matched by a valid CDB port this cycle. The issue operand is forwarded combinationally from the matching cdb_value, giving zero-cycle wakeup-to-issue. Registered state updates as normal.
- Undefined: one-cycle registered wakeup as in Behaviour.

Test Plan:
1. Dispatch tags 1/1, rs1_ready=rs2_ready=1, values 5/7, dest 3 -> next cycle issue_valid=1, issue_rs1_value=5, issue_rs2_value=7, issue_dest_tag=3. Ack -> free_count=8 after the edge.
2. Dispatch rs1_tag=2 (not ready), rs2 ready. CDB port1 broadcasts tag 2, value 10, one cycle later -> issue_valid=0 that cycle, 1 the next with issue_rs1_value=10. With RS_WAKEUP_BYPASS_EN: issue_valid=1 in the broadcast cycle.
3. rs1_tag=3, rs2_tag=4 waiting. Tag 4 broadcast, then tag 3 broadcast -> ready stays 0 after the first broadcast, issue_valid=1 after the second. Both values are 10.
4. Fill 8 slots, all ready -> dispatch_ready=0, free_count=0. Issue order follows dispatch order even after a mid-sequence squash-free refill. Ack while full plus dispatch_valid -> dispatch ignored that cycle, accepted the next.
5. Dispatch with rs1_tag=6 not ready while cdb port0 broadcasts tag 6, value 99, same cycle -> slot captures 99 and issues next cycle.
6. Squash with dispatch_valid=1 and issue_ack=1 -> free_count=8, issue_valid=0 next cycle. Assert reset mid-run -> outputs return to reset values immediately, without waiting for a clock edge.
